// File: rtl/nvram_upload_responder_if.sv
// ioctl upload-direction bus between hps_io (master) and the NVRAM upload responder (slave).
// Latency: plain wires, no storage.
// Backpressure: none; the HPS paces ioctl_rd strobes itself.
interface nvram_upload_responder_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_upload_req
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_upload_req
  );
endinterface

// File: rtl/nvram_upload_responder.sv
// Serves HPS upload (save) sessions: each ioctl_rd fetches one NVRAM byte onto ioctl_din; can request a session on save_trigger.
// Latency: ioctl_rd at N -> ram_rd at N+1 -> ioctl_din valid from N+2+RAM_LAT; out-of-range reads valid at N+1.
// Backpressure: none; HPS spaces strobes >= RAM_LAT+3 cycles, a newer strobe during a fetch restarts it. Optional: UPLOAD_CHECKSUM_EN.
module nvram_upload_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SIZE        = 1024,
  parameter int unsigned RAM_LAT     = 2,
  parameter logic [7:0]  INDEX       = 8'd4,
  parameter logic [23:0] REQ_TIMEOUT = 24'd4800000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  nvram_upload_responder_if.slave   ioctl,
  input  logic                      save_trigger,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_rd,
  input  logic [7:0]                ram_q,
  output logic                      pause_cpu,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT_UP = 3'd2;
  localparam logic [2:0] ST_SESSION = 3'd3;
  localparam logic [2:0] ST_FETCH   = 3'd4;

  localparam logic [24:0] SIZE_A  = 25'(SIZE);
  localparam logic [2:0]  LAT_V   = 3'(RAM_LAT);
  localparam logic [23:0] TO_LAST = REQ_TIMEOUT - 24'd1;

  logic [2:0]  state;
  logic [2:0]  lat_cnt;
  logic [23:0] to_cnt;
  logic        trig_q;
  logic [7:0]  din_r;
  logic [7:0]  oor_dat;
  logic        sel;
  logic        trig_rise;
  logic        rd_in_range;

  assign sel         = ioctl.ioctl_upload & (ioctl.ioctl_index == INDEX);
  assign trig_rise   = save_trigger & ~trig_q;
  assign rd_in_range = ioctl.ioctl_addr < SIZE_A;

  assign ioctl.ioctl_din        = din_r;
  assign ioctl.ioctl_upload_req = (state == ST_REQ);
  assign pause_cpu              = (state == ST_SESSION) | (state == ST_FETCH);
  assign busy                   = (state != ST_IDLE);

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] sum;
  // The byte just past the image is the two's complement of the bytes served so far.
  assign oor_dat = (ioctl.ioctl_addr == SIZE_A) ? (~sum + 8'd1) : 8'hFF;
`else
  assign oor_dat = 8'hFF;
`endif

  // Session state machine, RAM fetch sequencing and request timeout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      to_cnt   <= '0;
      trig_q   <= 1'b0;
      din_r    <= 8'h00;
      ram_addr <= '0;
      ram_rd   <= 1'b0;
      done     <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      trig_q <= save_trigger;
      ram_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A menu-opened session wins over a simultaneous save trigger.
          if (sel) begin
            state <= ST_SESSION;
`ifdef UPLOAD_CHECKSUM_EN
            sum   <= 8'h00;
`endif
          end else if (trig_rise) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          to_cnt <= '0;
          state  <= ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (sel) begin
            state <= ST_SESSION;
`ifdef UPLOAD_CHECKSUM_EN
            sum   <= 8'h00;
`endif
          end else if (to_cnt == TO_LAST) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        ST_SESSION, ST_FETCH: begin
          // Session close beats everything, including an in-flight fetch.
          if (!sel) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (ioctl.ioctl_rd) begin
            // The latest strobe always wins, even mid-fetch.
            if (rd_in_range) begin
              ram_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
              ram_rd   <= 1'b1;
              lat_cnt  <= LAT_V;
              state    <= ST_FETCH;
            end else begin
              din_r <= oor_dat;
              state <= ST_SESSION;
            end
          end else if (state == ST_FETCH) begin
            if (lat_cnt == 3'd0) begin
              din_r <= ram_q;
`ifdef UPLOAD_CHECKSUM_EN
              sum   <= sum + ram_q;
`endif
              state <= ST_SESSION;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
